// File: rtl/psum_bram_accum_ctrl.sv
// -----------------------------------------------------------------------------
// psum_bram_accum_ctrl
//
// PL-side initiator of the psum BRAM user bus. It accepts partial-sum beats
// from the PE array and either overwrites the addressed word (first
// contribution) or performs a read-modify-write accumulate. A zero-fill sweep
// clears words [0, i_clr_len) before a layer starts. Whenever psenb
// (i_conf_ctrl[2]) hands the BRAM to the PS, every strobe is dropped and
// progress stalls.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   i_conf_ctrl      bit 2 = psenb (PS owns BRAM); other bits ignored
//   i_psum_vld/o_psum_rdy, i_psum_addr (word index), i_psum_data,
//   i_psum_first     psum beat handshake and payload
//   i_clr_start      one-cycle pulse starting the zero-fill sweep
//   i_clr_len        number of words to clear, starting at word 0
//   mem_addr/mem_idat/mem_odat/mem_wren/mem_enb/mem_rst   BRAM user bus
//   o_busy           controller not idle
//   o_wr_cnt         completed BRAM writes, wraps at 2^32
// -----------------------------------------------------------------------------
module psum_bram_accum_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BYTE   = 4,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
  input  logic                  i_psum_vld,
  output logic                  o_psum_rdy,
  input  logic [ADDR_WIDTH-1:0] i_psum_addr,
  input  logic [DATA_WIDTH-1:0] i_psum_data,
  input  logic                  i_psum_first,
  input  logic                  i_clr_start,
  input  logic [ADDR_WIDTH-1:0] i_clr_len,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_idat,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  output logic [NUM_BYTE-1:0]   mem_wren,
  output logic                  mem_enb,
  output logic                  mem_rst,
  output logic                  o_busy,
  output logic [31:0]           o_wr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_CLEAR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_NUM_BYTE = ADDR_WIDTH'(NUM_BYTE);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_first;
  logic [DATA_WIDTH-1:0] r_sum;
  logic [ADDR_WIDTH-1:0] r_clr_idx;
  logic [ADDR_WIDTH-1:0] r_clr_len;
  logic [31:0]           r_wr_cnt;

  logic w_psenb;
  logic w_accept;
  logic w_clr_go;
  logic w_wr_fire;

  assign w_psenb  = i_conf_ctrl[2];
  // Ready is forced low during reset so no beat can be handed over while the
  // block is being cleared.
  assign o_psum_rdy = ~rst & (r_state == S_IDLE) & ~w_psenb & ~i_clr_start;
  assign w_accept   = i_psum_vld & o_psum_rdy;
  // A zero-length clear never leaves IDLE, so it issues no write.
  assign w_clr_go   = (r_state == S_IDLE) & i_clr_start & ~w_psenb &
                      (i_clr_len != '0);
  assign w_wr_fire  = ((r_state == S_WRITE) | (r_state == S_CLEAR)) & ~w_psenb;

  assign o_busy   = (r_state != S_IDLE);
  assign o_wr_cnt = r_wr_cnt;
  assign mem_rst  = 1'b0;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output is assigned a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_clr_go)      w_next = S_CLEAR;
        else if (w_accept) w_next = i_psum_first ? S_WRITE : S_READ;
      end
      S_READ:  if (!w_psenb) w_next = S_WAIT;
      // The read data returning this cycle is lost if the PS took the bus,
      // so the read has to be issued again.
      S_WAIT:  w_next = w_psenb ? S_READ : S_WRITE;
      S_WRITE: if (!w_psenb) w_next = S_IDLE;
      S_CLEAR: begin
        if (!w_psenb && (r_clr_idx == r_clr_len - 1'b1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // BRAM bus decode: driven only from registered state, never from i_psum_*
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_enb  = 1'b0;
    mem_wren = '0;
    mem_addr = '0;
    mem_idat = '0;
    if (!w_psenb) begin
      unique case (r_state)
        S_READ: begin
          mem_enb  = 1'b1;
          mem_addr = r_addr * LP_NUM_BYTE;
        end
        S_WRITE: begin
          mem_enb  = 1'b1;
          mem_wren = '1;
          mem_addr = r_addr * LP_NUM_BYTE;
          mem_idat = r_first ? r_data : r_sum;
        end
        S_CLEAR: begin
          mem_enb  = 1'b1;
          mem_wren = '1;
          mem_addr = r_clr_idx * LP_NUM_BYTE;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Capture, sum, sweep index and write counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_first   <= 1'b0;
      r_sum     <= '0;
      r_clr_idx <= '0;
      r_clr_len <= '0;
      r_wr_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= i_psum_addr;
        r_data  <= i_psum_data;
        r_first <= i_psum_first;
      end
      if (w_clr_go) begin
        r_clr_idx <= '0;
        r_clr_len <= i_clr_len;
      end else if (r_state == S_CLEAR && !w_psenb) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
      // Wrapping two's-complement add; overflow is deliberately discarded.
      if (r_state == S_WAIT && !w_psenb) begin
        r_sum <= mem_odat + r_data;
      end
      if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_psum_bram_accum_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for psum_bram_accum_ctrl: 256-word BRAM model with 1-cycle read
// latency, write scoreboard, table-driven beats plus hand-written sequences
// for the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_psum_bram_accum_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] i_conf_ctrl;
  logic        i_psum_vld;
  logic        o_psum_rdy;
  logic [31:0] i_psum_addr;
  logic [31:0] i_psum_data;
  logic        i_psum_first;
  logic        i_clr_start;
  logic [31:0] i_clr_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_idat;
  logic [31:0] mem_odat;
  logic [3:0]  mem_wren;
  logic        mem_enb;
  logic        mem_rst;
  logic        o_busy;
  logic [31:0] o_wr_cnt;

  psum_bram_accum_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_BYTE(4), .REG_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .i_conf_ctrl(i_conf_ctrl),
    .i_psum_vld(i_psum_vld), .o_psum_rdy(o_psum_rdy),
    .i_psum_addr(i_psum_addr), .i_psum_data(i_psum_data),
    .i_psum_first(i_psum_first), .i_clr_start(i_clr_start),
    .i_clr_len(i_clr_len), .mem_addr(mem_addr), .mem_idat(mem_idat),
    .mem_odat(mem_odat), .mem_wren(mem_wren), .mem_enb(mem_enb),
    .mem_rst(mem_rst), .o_busy(o_busy), .o_wr_cnt(o_wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        first;
    logic [31:0] exp;
  } vec_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] ref_mem [256];
  logic [31:0] tb_mem  [256];
  logic [31:0] exp_writes;
  int          n_checks;
  int          n_errors;

  // PS-side write port into the BRAM model (stands in for the AXI controller)
  logic        ps_wr_en;
  logic [7:0]  ps_wr_idx;
  logic [31:0] ps_wr_val;

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = '0;
  end

  always @(posedge clk) begin
    if (ps_wr_en) tb_mem[ps_wr_idx] <= ps_wr_val;
    if (mem_enb) begin
      if (mem_wren != 4'h0) tb_mem[mem_addr[9:2]] <= mem_idat;
      else                  mem_odat <= tb_mem[mem_addr[9:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: every BRAM write is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && mem_enb && mem_wren != 4'h0) begin
      check("write_while_psenb", {31'b0, i_conf_ctrl[2]}, 32'd0);
      check("wr_wren", {28'b0, mem_wren}, 32'hF);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write addr=0x%08h data=0x%08h expected no write",
                 mem_addr, mem_idat);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", mem_addr, mon_e.addr);
        check("wr_data", mem_idat, mon_e.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_beat(input logic [31:0] addr, input logic [31:0] data,
                           input logic first, input logic [31:0] exp);
    int t = 0;
    while (!o_psum_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("beat_rdy", {31'b0, o_psum_rdy}, 32'd1);
    i_psum_vld   = 1'b1;
    i_psum_addr  = addr;
    i_psum_data  = data;
    i_psum_first = first;
    exp_q.push_back({addr << 2, exp});
    exp_writes++;
    ref_mem[addr[7:0]] = exp;
    @(negedge clk);
    i_psum_vld = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || o_busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_q_empty", exp_q.size(), 32'd0);
  endtask

  vec_t        vecs[8];
  logic [31:0] ra, rd, rexp;
  logic        rf;
  int          bad_words;

  initial begin
    n_checks = 0; n_errors = 0; exp_writes = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    ps_wr_en = 1'b0; ps_wr_idx = '0; ps_wr_val = '0;
    rst = 1'b1; i_conf_ctrl = '0; i_psum_vld = 1'b1;
    i_psum_addr = 32'd5; i_psum_data = 32'd1; i_psum_first = 1'b1;
    i_clr_start = 1'b0; i_clr_len = '0;

    vecs[0] = '{32'd5,   32'd10,        1'b1, 32'd10};
    vecs[1] = '{32'd5,   32'hFFFF_FFFD, 1'b0, 32'd7};
    vecs[2] = '{32'd7,   32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{32'd7,   32'd2,         1'b0, 32'h0000_0001};
    vecs[4] = '{32'd255, 32'h8000_0000, 1'b1, 32'h8000_0000};
    vecs[5] = '{32'd255, 32'h8000_0000, 1'b0, 32'h0000_0000};
    vecs[6] = '{32'd0,   32'd123,       1'b1, 32'd123};
    vecs[7] = '{32'd0,   32'd877,       1'b0, 32'd1000};

    // ---- Reset ---------------------------------------------------------------
    @(negedge clk);
    check("rst_rdy",    {31'b0, o_psum_rdy}, 32'd0);
    check("rst_enb",    {31'b0, mem_enb},    32'd0);
    check("rst_wr_cnt", o_wr_cnt,            32'd0);
    check("rst_busy",   {31'b0, o_busy},     32'd0);
    i_psum_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", {31'b0, o_psum_rdy}, 32'd1);

    // ---- Table: first / accumulate / wrap ------------------------------------
    for (int i = 0; i < 8; i++)
      send_beat(vecs[i].addr, vecs[i].data, vecs[i].first, vecs[i].exp);
    drain();
    check("table_wr_cnt", o_wr_cnt, exp_writes);

    // ---- Accumulate timing: READ c1, WAIT c2, WRITE c3, rdy c4 ---------------
    i_psum_vld = 1'b1; i_psum_addr = 32'd5; i_psum_data = 32'd1;
    i_psum_first = 1'b0;
    exp_q.push_back({32'd20, 32'd8}); exp_writes++; ref_mem[5] = 32'd8;
    @(negedge clk);
    i_psum_vld = 1'b0;
    check("acc_c1_enb",  {31'b0, mem_enb},    32'd1);
    check("acc_c1_wren", {28'b0, mem_wren},   32'd0);
    check("acc_c1_addr", mem_addr,            32'd20);
    check("acc_c1_rdy",  {31'b0, o_psum_rdy}, 32'd0);
    @(negedge clk);
    check("acc_c2_enb",  {31'b0, mem_enb},    32'd0);
    @(negedge clk);
    check("acc_c3_wren", {28'b0, mem_wren},   32'hF);
    check("acc_c3_idat", mem_idat,            32'd8);
    @(negedge clk);
    check("acc_c4_rdy",  {31'b0, o_psum_rdy}, 32'd1);

    // ---- First-beat timing: WRITE c1, rdy c2 ---------------------------------
    i_psum_vld = 1'b1; i_psum_addr = 32'd3; i_psum_data = 32'h55;
    i_psum_first = 1'b1;
    exp_q.push_back({32'd12, 32'h55}); exp_writes++; ref_mem[3] = 32'h55;
    @(negedge clk);
    i_psum_vld = 1'b0;
    check("first_c1_wren", {28'b0, mem_wren}, 32'hF);
    check("first_c1_idat", mem_idat,          32'h55);
    @(negedge clk);
    check("first_c2_rdy", {31'b0, o_psum_rdy}, 32'd1);

    // ---- Clear len 4 with a simultaneous beat that must be refused -----------
    i_clr_start = 1'b1; i_clr_len = 32'd4;
    i_psum_vld = 1'b1; i_psum_addr = 32'd9; i_psum_data = 32'd77;
    i_psum_first = 1'b1;
    #1;
    check("clr_rdy_low", {31'b0, o_psum_rdy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({32'(i * 4), 32'd0});
      exp_writes++;
      ref_mem[i] = '0;
    end
    @(negedge clk);
    i_clr_start = 1'b0; i_psum_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("clr_enb",  {31'b0, mem_enb}, 32'd1);
      check("clr_addr", mem_addr,         32'(i * 4));
      @(negedge clk);
    end
    check("clr_done_busy", {31'b0, o_busy}, 32'd0);
    check("clr_wr_cnt", o_wr_cnt, exp_writes);

    // ---- Clear len 0: no write, stays idle ------------------------------------
    i_clr_start = 1'b1; i_clr_len = 32'd0;
    @(negedge clk);
    i_clr_start = 1'b0;
    check("clr0_busy", {31'b0, o_busy}, 32'd0);
    @(negedge clk);
    check("clr0_wr_cnt", o_wr_cnt, exp_writes);

    // ---- psenb during WAIT; PS rewrites the word meanwhile --------------------
    i_psum_vld = 1'b1; i_psum_addr = 32'd5; i_psum_data = 32'd5;
    i_psum_first = 1'b0;
    @(negedge clk);                       // cycle 1: READ
    i_psum_vld = 1'b0;
    @(negedge clk);                       // cycle 2: WAIT
    i_conf_ctrl = 32'h4;
    #1;
    check("ps_enb_0", {31'b0, mem_enb}, 32'd0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        ps_wr_en = 1'b1; ps_wr_idx = 8'd5; ps_wr_val = 32'd1000;
      end else begin
        ps_wr_en = 1'b0;
      end
      check("ps_enb", {31'b0, mem_enb}, 32'd0);
      check("ps_rdy", {31'b0, o_psum_rdy}, 32'd0);
    end
    @(negedge clk);
    i_conf_ctrl = '0;
    exp_q.push_back({32'd20, 32'd1005}); exp_writes++; ref_mem[5] = 32'd1005;
    #1;
    check("ps_reread_enb",  {31'b0, mem_enb},  32'd1);
    check("ps_reread_wren", {28'b0, mem_wren}, 32'd0);
    drain();
    check("ps_wr_cnt", o_wr_cnt, exp_writes);

    // ---- Random back-to-back beats against the reference ---------------------
    for (int n = 0; n < 200; n++) begin
      ra   = 32'($urandom_range(0, 255));
      rd   = $urandom;
      rf   = ($urandom_range(0, 3) == 0);
      rexp = rf ? rd : ref_mem[ra[7:0]] + rd;
      send_beat(ra, rd, rf, rexp);
    end
    drain();
    check("rand_wr_cnt", o_wr_cnt, exp_writes);
    @(negedge clk);
    bad_words = 0;
    for (int i = 0; i < 256; i++) begin
      if (tb_mem[i] !== ref_mem[i]) begin
        if (bad_words == 0)
          $display("FAIL mem_word[%0d] actual=0x%08h expected=0x%08h",
                   i, tb_mem[i], ref_mem[i]);
        bad_words++;
      end
    end
    check("mem_bad_words", bad_words, 32'd0);

    // ---- Reset mid-transaction: abort, no write afterwards --------------------
    i_psum_vld = 1'b1; i_psum_addr = 32'd9; i_psum_data = 32'd3;
    i_psum_first = 1'b0;
    @(negedge clk);
    i_psum_vld = 1'b0;
    @(negedge clk);                       // WAIT
    rst = 1'b1;
    #1;
    check("midrst_enb",    {31'b0, mem_enb},    32'd0);
    check("midrst_busy",   {31'b0, o_busy},     32'd0);
    check("midrst_wr_cnt", o_wr_cnt,            32'd0);
    check("midrst_rdy",    {31'b0, o_psum_rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_no_write", o_wr_cnt, 32'd0);
    check("midrst_idle_rdy", {31'b0, o_psum_rdy}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
